mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between the IF stage (instruction fetch) and the MEM stage (LWD/SWD driven by d_readM/d_writeM from the control unit).
- Issues one access at a time. Sequences a fixed-latency memory with an internal countdown. Returns a one-cycle done pulse plus registered read data to the winning requester.
- The pipeline stalls on the *_stall outputs.

Parameters:
- WORD_WIDTH, 16, data width of memory words
- ADDR_WIDTH, 16, address width
- MEM_LATENCY, 2, busy cycles per access; read data is valid in the last busy cycle; legal range 1..15

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- i_req  input  1  instruction fetch request; level, held until i_done
- i_addr  input  ADDR_WIDTH  fetch address; stable while i_req
- i_data  output  WORD_WIDTH  registered fetched instruction
- i_done  output  1  one-cycle completion pulse for fetch
- i_stall  output  1  i_req & ~i_done
- d_readM  input  1  data load request (LWD); level
- d_writeM  input  1  data store request (SWD); level
- d_addr  input  ADDR_WIDTH  data address; stable while requesting
- d_wdata  input  WORD_WIDTH  store data; stable while d_writeM
- d_rdata  output  WORD_WIDTH  registered load data
- d_done  output  1  one-cycle completion pulse for data access
- d_stall  output  1  (d_readM | d_writeM) & ~d_done
- mem_read  output  1  memory read strobe, held for whole busy period
- mem_write  output  1  memory write strobe, held for whole busy period
- mem_addr  output  ADDR_WIDTH  latched access address
- mem_wdata  output  WORD_WIDTH  latched store data
- mem_rdata  input  WORD_WIDTH  memory read data, valid in last busy cycle

Behaviour:
- States: IDLE, BUSY, DONE. Registers:
  - owner (0 = I, 1 = D)
  - last_grant (0 = I, 1 = D)
  - cnt (4 bits)
  - is_write
- Reset values:
  - state IDLE, owner 0, last_grant 1 (first tie goes to I), cnt 0, is_write 0
  - i_data, d_rdata, mem_addr, mem_wdata all 0
  - mem_read, mem_write, i_done, d_done all 0
- Reset asserted in any state: all of the above take effect at that edge. An in-flight access is abandoned, no done pulse is emitted, and strobes drop in the following cycle.
- IDLE arbitration, sampled at the clock edge:
  - d_pending = d_readM | d_writeM.
  - Only one of i_req / d_pending high: that requester wins.
  - Both high: the requester not equal to last_grant wins (round-robin).
  - On grant: owner and last_grant take the winner; latch mem_addr from i_addr or d_addr; latch mem_wdata = d_wdata; is_write = (winner D) & d_writeM; cnt = MEM_LATENCY; state goes to BUSY.
  - Neither high: stay in IDLE.
- Illegal input: d_readM and d_writeM both high is treated as a write.
- BUSY:
  - mem_read = ~is_write and mem_write = is_write, both Moore outputs from state.
  - cnt decrements each cycle.
  - In the cycle with cnt == 1: capture mem_rdata into i_data (owner I) or d_rdata (owner D read only; stores leave d_rdata unchanged). State goes to DONE.
- DONE:
  - Exactly one cycle. i_done = (owner == I) and d_done = (owner == D) are Moore outputs.
  - No strobes. No grant is taken in this cycle, even though the old request is still high.
  - Next state is IDLE.
- Latency:
  - Request sampled at edge of cycle 0 → busy cycles 1..MEM_LATENCY → done in cycle MEM_LATENCY+1 → IDLE in MEM_LATENCY+2.
  - Throughput: one access per MEM_LATENCY+2 cycles.
- Request withdrawal: a request dropping while owned in BUSY does not abort the access; the done pulse is still emitted.
- i_data and d_rdata hold their value until the next capture for that owner.
- mem_addr and mem_wdata hold their last latched value while in IDLE.

Test Plan:
- Reset, then idle for 5 cycles → all strobes/done 0, i_data = d_rdata = 0, state IDLE.
- i_req = 1, i_addr = 0x0010, memory returns 0xA5A5 (MEM_LATENCY = 2) → mem_read high cycles 1-2, mem_addr = 0x0010, i_done pulse in cycle 3, i_data = 0xA5A5, i_stall high cycles 0-2.
- i_req and d_readM both high from reset, d_addr = 0x0100 → I granted first (last_grant reset D), then D. Expect i_done at cycle 3, d_done at cycle 7, d_rdata = mem contents at 0x0100, and no re-grant to I during its DONE cycle.
- d_writeM = 1, d_addr = 0x0020, d_wdata = 0x1234 → mem_write high cycles 1-2 with mem_wdata = 0x1234, d_done at cycle 3, d_rdata unchanged.
- Both requesters held continuously for 4 accesses → grants alternate I, D, I, D, with a done every 4 cycles.
- Reset asserted in the second busy cycle of a D read → next cycle IDLE, no d_done, d_rdata stays 0, and a new i_req is served normally afterward.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch (I) and load/store (D).
// One access at a time: IDLE grant -> MEM_LATENCY BUSY cycles -> one DONE cycle.
module mem_port_arbiter #(
    parameter int WORD_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [WORD_WIDTH-1:0] i_data,
    output logic                  i_done,
    output logic                  i_stall,
    input  logic                  d_readM,
    input  logic                  d_writeM,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [WORD_WIDTH-1:0] d_wdata,
    output logic [WORD_WIDTH-1:0] d_rdata,
    output logic                  d_done,
    output logic                  d_stall,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    input  logic [WORD_WIDTH-1:0] mem_rdata,
    output logic [1:0]            o_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] LP_LATENCY = 4'(MEM_LATENCY);

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_owner;       // 0 = I, 1 = D
    logic                  r_last_grant;  // 0 = I, 1 = D
    logic                  r_is_write;
    logic [3:0]            r_cnt;
    logic [WORD_WIDTH-1:0] r_i_data;
    logic [WORD_WIDTH-1:0] r_d_rdata;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [WORD_WIDTH-1:0] r_mem_wdata;

    logic w_d_pending;
    logic w_any_req;
    logic w_grant_d;
    logic w_last_beat;

    assign w_d_pending = d_readM | d_writeM;
    assign w_any_req   = i_req | w_d_pending;
    // D wins when alone, or on a tie when I was served last.
    assign w_grant_d   = w_d_pending & (~i_req | ~r_last_grant);
    assign w_last_beat = (r_cnt == 4'd1);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_any_req) w_next_state = S_BUSY;
            S_BUSY: if (w_last_beat) w_next_state = S_DONE;
            S_DONE: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_is_write   <= 1'b0;
            r_cnt        <= 4'd0;
            r_i_data     <= '0;
            r_d_rdata    <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner      <= w_grant_d;
                        r_last_grant <= w_grant_d;
                        r_mem_addr   <= w_grant_d ? d_addr : i_addr;
                        r_mem_wdata  <= d_wdata;
                        r_is_write   <= w_grant_d & d_writeM;
                        r_cnt        <= LP_LATENCY;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                    // Read data is only valid in the final busy cycle.
                    if (w_last_beat) begin
                        if (!r_owner) begin
                            r_i_data <= mem_rdata;
                        end else if (!r_is_write) begin
                            r_d_rdata <= mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_read  = (r_state == S_BUSY) & ~r_is_write;
    assign mem_write = (r_state == S_BUSY) & r_is_write;
    assign i_done    = (r_state == S_DONE) & ~r_owner;
    assign d_done    = (r_state == S_DONE) & r_owner;
    assign i_stall   = i_req & ~i_done;
    assign d_stall   = w_d_pending & ~d_done;
    assign i_data    = r_i_data;
    assign d_rdata   = r_d_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign o_state   = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, checked each
// cycle against a transaction-timeline model (grant cycle + fixed latency arithmetic).
module tb_mem_port_arbiter;

    localparam int W = 16;
    localparam int A = 16;
    localparam int L = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_req;
    logic [A-1:0] i_addr;
    logic [W-1:0] i_data;
    logic         i_done;
    logic         i_stall;
    logic         d_readM;
    logic         d_writeM;
    logic [A-1:0] d_addr;
    logic [W-1:0] d_wdata;
    logic [W-1:0] d_rdata;
    logic         d_done;
    logic         d_stall;
    logic         mem_read;
    logic         mem_write;
    logic [A-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata;
    logic [1:0]   o_state;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WORD_WIDTH(W), .ADDR_WIDTH(A), .MEM_LATENCY(L)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_done(i_done), .i_stall(i_stall),
        .d_readM(d_readM), .d_writeM(d_writeM), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .o_state(o_state)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: the current access is described by its grant cycle.
    bit           acc_valid;
    int           acc_start;
    bit           acc_owner;
    bit           acc_write;
    logic [A-1:0] acc_addr;
    logic [W-1:0] acc_wdata;
    int           free_at;
    bit           last_grant;
    logic [W-1:0] exp_i_data, exp_d_rdata, exp_mem_wdata;
    logic [A-1:0] exp_mem_addr;
    bit           last_i_done, last_d_done;
    logic [W-1:0] mem_model [0:255];

    bit           record;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic void model_reset(input int k);
        acc_valid     = 1'b0;
        acc_start     = -100;
        free_at       = k + 1;
        last_grant    = 1'b1;
        exp_i_data    = '0;
        exp_d_rdata   = '0;
        exp_mem_addr  = '0;
        exp_mem_wdata = '0;
    endfunction

    task automatic drive_mem();
        if (acc_valid && !acc_write && cyc == acc_start + L)
            mem_rdata = mem_model[acc_addr[7:0]];
        else
            mem_rdata = W'($urandom);
    endtask

    task automatic cycle();
        bit busy;
        bit done;
        bit win;
        @(negedge clk);
        busy = acc_valid && cyc > acc_start && cyc <= acc_start + L;
        done = acc_valid && cyc == acc_start + L + 1;
        chk("mem_read",  mem_read,  busy & ~acc_write);
        chk("mem_write", mem_write, busy & acc_write);
        chk("i_done",    i_done,    done & ~acc_owner);
        chk("d_done",    d_done,    done & acc_owner);
        chk("i_stall",   i_stall,   i_req & ~(done & ~acc_owner));
        chk("d_stall",   d_stall,   (d_readM | d_writeM) & ~(done & acc_owner));
        chk("state",     o_state,   busy ? 2'd1 : (done ? 2'd2 : 2'd0));
        chk("i_data",    i_data,    exp_i_data);
        chk("d_rdata",   d_rdata,   exp_d_rdata);
        chk("mem_addr",  mem_addr,  exp_mem_addr);
        chk("mem_wdata", mem_wdata, exp_mem_wdata);
        last_i_done = done & ~acc_owner;
        last_d_done = done & acc_owner;
        if (record) begin
            if (i_done) obs_q.push_back(W'(0));
            if (d_done) obs_q.push_back(W'(1));
        end
        if (reset) begin
            model_reset(cyc);
        end else begin
            if (acc_valid && cyc == acc_start + L) begin
                if (acc_write) mem_model[acc_addr[7:0]] = acc_wdata;
                else if (acc_owner) exp_d_rdata = mem_model[acc_addr[7:0]];
                else exp_i_data = mem_model[acc_addr[7:0]];
            end
            if (cyc >= free_at && (i_req || d_readM || d_writeM)) begin
                if (i_req && (d_readM || d_writeM)) win = ~last_grant;
                else win = ~i_req;
                acc_valid     = 1'b1;
                acc_start     = cyc;
                acc_owner     = win;
                last_grant    = win;
                acc_write     = win && d_writeM;
                acc_addr      = win ? d_addr : i_addr;
                acc_wdata     = d_wdata;
                exp_mem_addr  = acc_addr;
                exp_mem_wdata = d_wdata;
                free_at       = cyc + L + 2;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        drive_mem();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        reset = 1'b1; i_req = 1'b0; i_addr = '0; d_readM = 1'b0; d_writeM = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0; record = 1'b0;
        last_i_done = 1'b0; last_d_done = 1'b0;
        for (int i = 0; i < 256; i++) mem_model[i] = W'($urandom);
        mem_model[8'h10] = 16'hA5A5;
        mem_model[8'h00] = 16'h5A3C;
        repeat (2) @(posedge clk);
        #1;
        model_reset(-1);
        reset = 1'b0;
        drive_mem();

        // Idle after reset
        run(5);

        // Single fetch
        i_req = 1'b1; i_addr = 16'h0010;
        run(4);
        i_req = 1'b0;
        run(1);
        chk("fetch_data", i_data, 16'hA5A5);

        // Tie from reset: I first, then D; no re-grant to I in its DONE cycle
        reset = 1'b1; run(1); reset = 1'b0;
        i_req = 1'b1; i_addr = 16'h0010; d_readM = 1'b1; d_addr = 16'h0100;
        run(4);
        i_req = 1'b0;
        run(4);
        d_readM = 1'b0;
        run(1);
        chk("load_data", d_rdata, 16'h5A3C);

        // Store leaves d_rdata unchanged; read-back sees stored data
        d_writeM = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
        run(4);
        d_writeM = 1'b0;
        run(1);
        chk("store_keeps_rdata", d_rdata, 16'h5A3C);
        d_readM = 1'b1;
        run(4);
        d_readM = 1'b0;
        run(1);
        chk("store_readback", d_rdata, 16'h1234);

        // Both held for four accesses: I, D, I, D
        reset = 1'b1; run(1); reset = 1'b0;
        exp_q = {W'(0), W'(1), W'(0), W'(1)};
        obs_q.delete();
        record = 1'b1;
        i_req = 1'b1; i_addr = 16'h0010; d_readM = 1'b1; d_addr = 16'h0020;
        run(16);
        i_req = 1'b0; d_readM = 1'b0;
        run(2);
        record = 1'b0;
        chk("rr_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk("rr_order", obs_q[i], exp_q[i]);

        // Reset in second busy cycle of a D read abandons it
        reset = 1'b1; run(1); reset = 1'b0;
        d_readM = 1'b1; d_addr = 16'h0100;
        run(2);
        reset = 1'b1; run(1); reset = 1'b0; d_readM = 1'b0;
        run(3);
        chk("abandon_rdata", d_rdata, 16'h0000);
        i_req = 1'b1; i_addr = 16'h0010;
        run(4);
        i_req = 1'b0;
        run(1);
        chk("after_abandon_fetch", i_data, 16'hA5A5);

        // Read and write both high is a write
        d_readM = 1'b1; d_writeM = 1'b1; d_addr = 16'h0030; d_wdata = 16'hBEEF;
        run(4);
        d_writeM = 1'b0;
        run(4);
        d_readM = 1'b0;
        run(1);
        chk("rw_as_write", d_rdata, 16'hBEEF);

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            if (i_req && last_i_done) begin
                i_req = 1'b0;
            end else if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1'b1;
                i_addr = A'($urandom_range(0, 255));
            end
            if ((d_readM || d_writeM) && last_d_done) begin
                d_readM = 1'b0; d_writeM = 1'b0;
            end else if (!(d_readM || d_writeM) && $urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0, 1: d_readM = 1'b1;
                    2: d_writeM = 1'b1;
                    default: begin d_readM = 1'b1; d_writeM = 1'b1; end
                endcase
                d_addr = A'($urandom_range(0, 255));
                d_wdata = W'($urandom);
            end
            reset = (cyc >= free_at) && ($urandom_range(0, 60) == 0);
            cycle();
        end
        reset = 1'b0; i_req = 1'b0; d_readM = 1'b0; d_writeM = 1'b0;
        run(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
